// File: rtl/wb_stream_writer_circ.sv
// Wishbone burst-read DMA engine feeding a valid/ready stream through a word FIFO
// and a width down-converter; supports ring-buffer mode, stop, half/done irqs and bus-error abort.
//
// state   | meaning
// IDLE    | no transfer; waits for start
// WAIT    | transfer active; holds until the FIFO can take the whole next burst
// BURST   | Wishbone cycle in progress, one FIFO write per ack
module wb_stream_writer_circ #(
  parameter int WB_DW         = 32,
  parameter int WB_AW         = 32,
  parameter int STREAM_DW     = 8,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [WB_AW-1:0]       wbm_adr_o,
  output logic [WB_DW/8-1:0]     wbm_sel_o,
  output logic                   wbm_we_o,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic [2:0]             wbm_cti_o,
  output logic [1:0]             wbm_bte_o,
  input  logic [WB_DW-1:0]       wbm_dat_i,
  input  logic                   wbm_ack_i,
  input  logic                   wbm_err_i,
  output logic [STREAM_DW-1:0]   stream_m_data_o,
  output logic                   stream_m_valid_o,
  input  logic                   stream_m_ready_i,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   circular,
  input  logic [WB_AW-1:0]       start_adr,
  input  logic [WB_AW-1:0]       buf_size,
  input  logic [WB_AW-1:0]       burst_size,
  output logic                   busy,
  output logic                   irq_half,
  output logic                   irq_done,
  output logic                   err
);

  localparam int BPW = WB_DW / 8;
  localparam int NB  = WB_DW / STREAM_DW;
  localparam int SLW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  localparam logic [FIFO_AW:0]   DEPTH    = (FIFO_AW+1)'(2**FIFO_AW);
  localparam logic [WB_AW-1:0]   MAXB     = WB_AW'(MAX_BURST_LEN);
  localparam logic [WB_AW-1:0]   ADR_MASK = ~(WB_AW'(BPW - 1));
  localparam logic [WB_AW-1:0]   ONE      = WB_AW'(1);

  logic [1:0]           r_state;
  logic [WB_AW-1:0]     r_adr;
  logic [WB_AW-1:0]     r_start_adr;
  logic [WB_AW-1:0]     r_buf_size;
  logic [WB_AW-1:0]     r_burst_len;
  logic                 r_circular;
  logic [WB_AW-1:0]     r_remaining;
  logic [WB_AW-1:0]     r_words_done;
  logic [WB_AW-1:0]     r_beat_cnt;
  logic                 r_stop_pend;
  logic                 r_irq_half;
  logic                 r_irq_done;
  logic                 r_err;

  logic [WB_DW-1:0]     r_mem [2**FIFO_AW];
  logic [FIFO_AW:0]     r_wptr;
  logic [FIFO_AW:0]     r_rptr;

  logic [WB_DW-1:0]     r_cw;
  logic                 r_cvalid;
  logic [SLW-1:0]       r_slice;

  logic [FIFO_AW:0]     w_count;
  logic [FIFO_AW:0]     w_free;
  logic                 w_empty;
  logic [WB_AW-1:0]     w_blen;
  logic                 w_fifo_ok;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fire;
  logic                 w_last;
  logic                 w_stop_any;
  logic [WB_AW-1:0]     w_rem_next;
  logic [WB_AW-1:0]     w_wd_next;

  assign w_count    = r_wptr - r_rptr;
  assign w_free     = DEPTH - w_count;
  assign w_empty    = (w_count == '0);
  assign w_push     = (r_state == S_BURST) && wbm_ack_i && !wbm_err_i;
  assign w_stop_any = r_stop_pend || stop;
  assign w_rem_next = r_remaining - ONE;
  assign w_wd_next  = r_words_done + ONE;

  always_comb begin
    w_blen = r_burst_len;
    if (r_remaining < w_blen) w_blen = r_remaining;
    if (MAXB < w_blen)        w_blen = MAXB;
  end

  // Space for the whole burst is reserved up front, so the FIFO never overflows.
  assign w_fifo_ok = (WB_AW'(w_free) >= w_blen);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_adr        <= '0;
      r_start_adr  <= '0;
      r_buf_size   <= '0;
      r_burst_len  <= '0;
      r_circular   <= 1'b0;
      r_remaining  <= '0;
      r_words_done <= '0;
      r_beat_cnt   <= '0;
      r_stop_pend  <= 1'b0;
      r_irq_half   <= 1'b0;
      r_irq_done   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_irq_half <= 1'b0;
      r_irq_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
            if (buf_size != '0) begin
              r_start_adr  <= start_adr & ADR_MASK;
              r_adr        <= start_adr & ADR_MASK;
              r_buf_size   <= buf_size;
              r_remaining  <= buf_size;
              r_words_done <= '0;
              r_burst_len  <= (burst_size == '0) ? ONE : burst_size;
              r_circular   <= circular;
              r_state      <= S_WAIT;
            end else begin
              r_irq_done <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (stop) begin
            r_irq_done <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_fifo_ok) begin
            r_beat_cnt <= w_blen;
            r_state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (stop) r_stop_pend <= 1'b1;
          if (wbm_err_i) begin
            r_err      <= 1'b1;
            r_irq_done <= 1'b1;
            r_state    <= S_IDLE;
          end else if (wbm_ack_i) begin
            r_adr        <= r_adr + WB_AW'(BPW);
            r_remaining  <= w_rem_next;
            r_words_done <= w_wd_next;
            r_beat_cnt   <= r_beat_cnt - ONE;
            if (w_wd_next == (r_buf_size >> 1)) r_irq_half <= 1'b1;
            if (r_beat_cnt == ONE) begin
              if (w_rem_next == '0) begin
                r_irq_done <= 1'b1;
                if (r_circular && !w_stop_any) begin
                  r_adr        <= r_start_adr;
                  r_remaining  <= r_buf_size;
                  r_words_done <= '0;
                  r_state      <= S_WAIT;
                end else begin
                  r_state <= S_IDLE;
                end
              end else if (w_stop_any) begin
                r_irq_done <= 1'b1;
                r_state    <= S_IDLE;
              end else begin
                r_state <= S_WAIT;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= wbm_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Reload on the last slice's handshake so consecutive words stream without a bubble.
  assign w_fire = r_cvalid && stream_m_ready_i;
  assign w_last = (r_slice == SLW'(NB - 1));
  assign w_pop  = (!r_cvalid || (w_fire && w_last)) && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cw     <= '0;
      r_cvalid <= 1'b0;
      r_slice  <= '0;
    end else if (w_pop) begin
      r_cw     <= r_mem[r_rptr[FIFO_AW-1:0]];
      r_cvalid <= 1'b1;
      r_slice  <= '0;
    end else if (w_fire && w_last) begin
      r_cvalid <= 1'b0;
    end else if (w_fire) begin
      r_cw    <= r_cw >> STREAM_DW;
      r_slice <= r_slice + 1'b1;
    end
  end

  assign wbm_adr_o        = r_adr;
  assign wbm_sel_o        = '1;
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = (r_state == S_BURST);
  assign wbm_stb_o        = wbm_cyc_o;
  assign wbm_cti_o        = !wbm_cyc_o ? 3'b000 : ((r_beat_cnt == ONE) ? 3'b111 : 3'b010);
  assign wbm_bte_o        = 2'b00;
  assign stream_m_data_o  = r_cw[STREAM_DW-1:0];
  assign stream_m_valid_o = r_cvalid;
  assign busy             = (r_state != S_IDLE);
  assign irq_half         = r_irq_half;
  assign irq_done         = r_irq_done;
  assign err              = r_err;

endmodule

// File: tb/tb_wb_stream_writer_circ.sv
// Bench for wb_stream_writer_circ: Wishbone memory model, expected-beat and expected-byte
// scoreboards filled at stimulus time, scenario tasks run in sequence.
module tb_wb_stream_writer_circ;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int SDW   = 8;
  localparam int FAW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WB_AW-1:0]  wbm_adr_o;
  logic [WB_DW/8-1:0] wbm_sel_o;
  logic              wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]        wbm_cti_o;
  logic [1:0]        wbm_bte_o;
  logic [WB_DW-1:0]  wbm_dat_i;
  logic              wbm_ack_i, wbm_err_i;
  logic [SDW-1:0]    stream_m_data_o;
  logic              stream_m_valid_o;
  logic              stream_m_ready_i = 1'b0;
  logic              start = 1'b0, stop = 1'b0, circular = 1'b0;
  logic [WB_AW-1:0]  start_adr = '0, buf_size = '0, burst_size = '0;
  logic              busy, irq_half, irq_done, err;

  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct { logic [31:0] adr; logic [2:0] cti; } beat_t;
  beat_t      exp_bus[$];
  logic [7:0] exp_byte[$];
  int         ack_snap[$];
  int ack_total = 0, byte_total = 0, half_cnt = 0, done_cnt = 0, half_at = -1;

  int   rdy_mode = 0;
  logic ack_en = 1'b1, err_arm = 1'b0;
  int   err_beat = 0, beat_in_cyc = 0;

  wb_stream_writer_circ #(.WB_DW(WB_DW), .WB_AW(WB_AW), .STREAM_DW(SDW), .FIFO_AW(FAW)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i),
    .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
    .stream_m_ready_i(stream_m_ready_i),
    .start(start), .stop(stop), .circular(circular), .start_adr(start_adr),
    .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .irq_half(irq_half), .irq_done(irq_done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h200) return 32'h44332211;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign wbm_dat_i = mem_rd(wbm_adr_o);
  assign wbm_err_i = wbm_cyc_o && err_arm && (beat_in_cyc == err_beat);
  assign wbm_ack_i = wbm_cyc_o && ack_en && !wbm_err_i;

  always @(posedge clk) begin
    if (!wbm_cyc_o) beat_in_cyc <= 0;
    else if (wbm_ack_i) beat_in_cyc <= beat_in_cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: stream_m_ready_i = 1'b1;
      1: stream_m_ready_i = ~stream_m_ready_i;
      default: stream_m_ready_i = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    beat_t      e;
    logic [7:0] b;
    if (irq_half) begin half_cnt++; half_at = ack_total; end
    if (irq_done) done_cnt++;
    if (wbm_cyc_o && wbm_ack_i) begin
      ack_snap.push_back(byte_total);
      ack_total++;
      chk_cnt++;
      if (exp_bus.size() == 0)
        $display("FAIL bus_beat: unexpected beat adr=%h cti=%b", wbm_adr_o, wbm_cti_o);
      else begin
        e = exp_bus.pop_front();
        if (wbm_adr_o !== e.adr || wbm_cti_o !== e.cti)
          $display("FAIL bus_beat: got adr=%h cti=%b, want adr=%h cti=%b",
                   wbm_adr_o, wbm_cti_o, e.adr, e.cti);
        else pass_cnt++;
      end
    end
    if (stream_m_valid_o && stream_m_ready_i) begin
      byte_total++;
      chk_cnt++;
      if (exp_byte.size() == 0)
        $display("FAIL stream_byte: unexpected byte %h", stream_m_data_o);
      else begin
        b = exp_byte.pop_front();
        if (stream_m_data_o !== b)
          $display("FAIL stream_byte: got %h, want %h", stream_m_data_o, b);
        else pass_cnt++;
      end
    end
  end

  task automatic push_burst(input logic [31:0] base, input int n);
    beat_t       e;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      e.adr = base + 32'(4 * i);
      e.cti = (i == n - 1) ? 3'b111 : 3'b010;
      exp_bus.push_back(e);
      w = mem_rd(e.adr);
      for (int k = 0; k < 4; k++) exp_byte.push_back(w[8*k +: 8]);
    end
  endtask

  task automatic clear_stats();
    half_cnt = 0; done_cnt = 0; half_at = -1; ack_total = 0; byte_total = 0;
    ack_snap.delete();
  endtask

  task automatic pulse_start(input logic [31:0] adr, input logic [31:0] bs,
                             input logic [31:0] bl, input logic circ);
    @(posedge clk); #1;
    start_adr = adr; buf_size = bs; burst_size = bl; circular = circ; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_bus.size() == 0 && exp_byte.size() == 0) begin ok = 1'b1; break; end
    end
    if (ok) repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_cti_o, stream_m_valid_o, stream_m_data_o,
         busy, irq_half, irq_done, err} !== '0)
      $display("FAIL reset_outputs: cyc=%b adr=%h cti=%b valid=%b busy=%b err=%b",
               wbm_cyc_o, wbm_adr_o, wbm_cti_o, stream_m_valid_o, busy, err);
    else pass_cnt++;
    chk_cnt++;
    if (wbm_sel_o !== 4'hF || wbm_we_o !== 1'b0 || wbm_bte_o !== 2'b00)
      $display("FAIL const_outputs: sel=%h we=%b bte=%b, want F 0 00", wbm_sel_o, wbm_we_o, wbm_bte_o);
    else pass_cnt++;
  endtask

  task automatic test_linear();
    bit ok;
    clear_stats(); rdy_mode = 0;
    push_burst(32'h100, 4); push_burst(32'h110, 4);
    pulse_start(32'h100, 8, 4, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL linear_busy: got %b want 1", busy); else pass_cnt++;
    wait_done(2000, ok);
    chk_cnt++;
    if (!ok) $display("FAIL linear_timeout: transfer not complete, beats left %0d", exp_bus.size());
    else pass_cnt++;
    chk_cnt++;
    if (half_cnt !== 1 || half_at !== 4)
      $display("FAIL linear_irq_half: count=%0d at_ack=%0d, want 1 at 4", half_cnt, half_at);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt !== 1) $display("FAIL linear_irq_done: count=%0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_downconv();
    bit ok;
    clear_stats(); rdy_mode = 1;
    push_burst(32'h200, 2);
    pulse_start(32'h200, 2, 2, 1'b0);
    wait_done(2000, ok);
    chk_cnt++;
    if (!ok || byte_total !== 8)
      $display("FAIL downconv_bytes: done=%0d bytes=%0d want 8", ok, byte_total);
    else pass_cnt++;
    rdy_mode = 0;
  endtask

  task automatic test_circular_stop();
    bit ok;
    int seen;
    clear_stats(); rdy_mode = 0;
    push_burst(32'h300, 4); push_burst(32'h310, 2); push_burst(32'h300, 4);
    pulse_start(32'h300, 6, 4, 1'b1);
    seen = 0;
    for (int i = 0; i < 2000 && seen < 2; i++) begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_ack_i && wbm_adr_o == 32'h300) seen++;
    end
    chk_cnt++;
    if (seen < 2) $display("FAIL circ_wrap: start_adr revisited %0d times, want 2", seen);
    else pass_cnt++;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(3000, ok);
    chk_cnt++;
    if (!ok || ack_total !== 10)
      $display("FAIL circ_stop: done=%0d beats=%0d want 10", ok, ack_total);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt !== 2 || half_cnt !== 2)
      $display("FAIL circ_irqs: done=%0d half=%0d want 2 2", done_cnt, half_cnt);
    else pass_cnt++;
  endtask

  task automatic test_bus_error();
    bit ok;
    int n;
    clear_stats(); rdy_mode = 0;
    err_arm = 1'b1; err_beat = 1;
    push_burst(32'h400, 1);
    exp_bus[0].cti = 3'b010;
    pulse_start(32'h400, 8, 4, 1'b0);
    n = 0;
    while (n < 500 && !wbm_err_i) begin @(negedge clk); n++; end
    chk_cnt++;
    if (n >= 500) $display("FAIL err_seen: bus error never driven");
    else pass_cnt++;
    @(negedge clk);
    err_arm = 1'b0;
    chk_cnt++;
    if (wbm_cyc_o !== 1'b0 || err !== 1'b1)
      $display("FAIL err_abort: cyc=%b err=%b, want 0 1", wbm_cyc_o, err);
    else pass_cnt++;
    wait_done(500, ok);
    chk_cnt++;
    if (!ok || byte_total !== 4 || done_cnt !== 1 || err !== 1'b1)
      $display("FAIL err_drain: done=%0d bytes=%0d irq_done=%0d err=%b, want 1 4 1 1",
               ok, byte_total, done_cnt, err);
    else pass_cnt++;
    push_burst(32'h500, 1);
    pulse_start(32'h500, 1, 1, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err); else pass_cnt++;
    wait_done(500, ok);
    chk_cnt++;
    if (!ok) $display("FAIL err_restart: transfer after error not complete"); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    clear_stats(); rdy_mode = 2;
    push_burst(32'h600, 4); push_burst(32'h610, 4);
    pulse_start(32'h600, 8, 4, 1'b0);
    n = 0;
    while (n < 200 && ack_total < 4) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    chk_cnt++;
    if (ack_total !== 4 || wbm_cyc_o !== 1'b0)
      $display("FAIL bp_hold: beats=%0d cyc=%b, want 4 0", ack_total, wbm_cyc_o);
    else pass_cnt++;
    rdy_mode = 0;
    wait_done(2000, ok);
    chk_cnt++;
    if (!ok || ack_snap.size() !== 8)
      $display("FAIL bp_complete: done=%0d beats=%0d want 8", ok, ack_snap.size());
    else pass_cnt++;
    chk_cnt++;
    if (ack_snap.size() < 5 || ack_snap[4] < 12)
      $display("FAIL bp_reserve: bytes drained before 2nd burst=%0d, want >=12",
               (ack_snap.size() < 5) ? -1 : ack_snap[4]);
    else pass_cnt++;
  endtask

  task automatic test_edge_cases();
    bit ok;
    int n;
    clear_stats(); rdy_mode = 0;
    pulse_start(32'h0, 0, 4, 1'b0);
    @(negedge clk);
    chk_cnt++;
    if (irq_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_size: irq_done=%b busy=%b, want 1 0", irq_done, busy);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (done_cnt !== 1 || ack_total !== 0)
      $display("FAIL zero_size_quiet: irq_done=%0d beats=%0d, want 1 0", done_cnt, ack_total);
    else pass_cnt++;

    clear_stats();
    push_burst(32'h700, 4);
    pulse_start(32'h700, 4, 4, 1'b0);
    pulse_start(32'h800, 2, 1, 1'b0);
    wait_done(2000, ok);
    chk_cnt++;
    if (!ok || ack_total !== 4 || done_cnt !== 1)
      $display("FAIL start_busy: done=%0d beats=%0d irq_done=%0d, want 1 4 1", ok, ack_total, done_cnt);
    else pass_cnt++;

    clear_stats(); rdy_mode = 2; ack_en = 1'b0;
    pulse_start(32'h900, 4, 4, 1'b0);
    n = 0;
    while (n < 100 && !wbm_cyc_o) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h900 || wbm_cti_o !== 3'b010)
      $display("FAIL wait_state_hold: cyc=%b adr=%h cti=%b, want 1 900 010", wbm_cyc_o, wbm_adr_o, wbm_cti_o);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_cti_o, stream_m_valid_o, busy, irq_half, irq_done, err} !== '0)
      $display("FAIL rst_mid_burst: cyc=%b adr=%h busy=%b, want all 0", wbm_cyc_o, wbm_adr_o, busy);
    else pass_cnt++;
    rst = 1'b0; ack_en = 1'b1; rdy_mode = 0;
    exp_bus.delete(); exp_byte.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_linear();
    test_downconv();
    test_circular_stop();
    test_bus_error();
    test_backpressure();
    test_edge_cases();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
